// File: rtl/fifo_top.sv
// fifo_top -- single-clock synchronous FIFO with a registered read port.
//
// Ports:
//   clk      in   single clock; all state changes on its rising edge
//   rst      in   asynchronous, active-low reset
//   wr_en    in   write request
//   wr_data  in   DATA_SIZE-bit word to store
//   rd_en    in   read request
//   rd_data  out  DATA_SIZE-bit registered read word
//   full     out  high when DEPTH words are stored
//   empty    out  high when no words are stored
//
// Handshake: a write is accepted on a rising edge where wr_en=1 and full=0.
// A read is accepted on a rising edge where rd_en=1 and empty=0. An accepted
// read places the word on rd_data straight after that edge. Requests made
// while the matching flag is set are dropped, not queued. rd_data holds its
// value on every edge without an accepted read.
module fifo_top #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 4,
  parameter int DEPTH     = 16  // must equal 2**ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 rd_en,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic                 full,
  output logic                 empty
);

  // One extra pointer bit acts as a wrap flag. It separates the full case
  // from the empty case when the index bits are equal.
  localparam int PTR_W = ADDR_SIZE + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [DATA_SIZE-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [DATA_SIZE-1:0] rd_data_q, rd_data_d;

  logic wr_acc;
  logic rd_acc;
  logic ptr_idx_eq;

  // Flags are decoded from the registered pointers only. They therefore
  // change in the cycle after the edge that moved a pointer.
  assign ptr_idx_eq = (wr_ptr_q[ADDR_SIZE-1:0] == rd_ptr_q[ADDR_SIZE-1:0]);
  assign empty      = ptr_idx_eq && (wr_ptr_q[ADDR_SIZE] == rd_ptr_q[ADDR_SIZE]);
  assign full       = ptr_idx_eq && (wr_ptr_q[ADDR_SIZE] != rd_ptr_q[ADDR_SIZE]);

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      rd_ptr_d  = rd_ptr_q + PTR_ONE;
      rd_data_d = mem_q[rd_ptr_q[ADDR_SIZE-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage is not reset. Clearing the pointers is enough to discard the
  // stored words.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q[ADDR_SIZE-1:0]] <= wr_data;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_fifo_top.sv
// tb_fifo_top -- self-checking bench for fifo_top. A queue of stored words
// is the reference. Each edge's accepted read and write are derived from
// the occupancy before that edge.
module tb_fifo_top;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          full;
  logic          empty;

  int checks = 0;
  int errors = 0;

  // Reference state: stored words in FIFO order, plus the expected read word.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] rd_exp;
  int            words_read;

  fifo_top #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_rd_data"}, 32'(rd_data), 32'(rd_exp));
    check({tag, "_empty"}, 32'(empty), 32'(exp_q.size() == 0));
    check({tag, "_full"}, 32'(full), 32'(exp_q.size() == DEPTH));
  endtask

  // Drive one cycle of requests. Then apply the reference rules for that
  // edge and compare all outputs shortly after it.
  task automatic step(input logic wr, input logic [DW-1:0] data,
                      input logic rd, input string tag);
    bit was_full;
    bit was_empty;
    @(negedge clk);
    wr_en   = wr;
    wr_data = data;
    rd_en   = rd;
    @(posedge clk);
    was_full  = (exp_q.size() == DEPTH);
    was_empty = (exp_q.size() == 0);
    if (rd && !was_empty) begin
      rd_exp = exp_q.pop_front();
      words_read++;
    end
    if (wr && !was_full) exp_q.push_back(data);
    #1;
    check_flags(tag);
  endtask

  // Assert reset away from any edge and check that it acts at once.
  task automatic do_reset(input string tag);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2 rst = 1'b0;
    exp_q.delete();
    rd_exp = '0;
    #1;
    check_flags(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int n;
    int writes;
    rst        = 1'b1;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    wr_data    = '0;
    rd_exp     = '0;
    words_read = 0;

    // Reset state, then a read while empty.
    do_reset("reset");
    step(1'b0, 8'h00, 1'b1, "rd_empty");

    // A single word goes in and comes back out.
    step(1'b1, 8'h24, 1'b0, "wr_24");
    step(1'b0, 8'h00, 1'b1, "rd_24");
    check("rd_24_const", 32'(rd_data), 32'h24);

    // Fill to full, try one more write, then drain in order.
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(i), 1'b0, "fill");
    check("full_after_16", 32'(full), 32'd1);
    step(1'b1, 8'hAA, 1'b0, "wr_when_full");
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 8'h00, 1'b1, "drain");
      check("drain_order", 32'(rd_data), 32'(i));
    end
    check("empty_after_drain", 32'(empty), 32'd1);

    // Simultaneous read and write while full: read wins, write dropped.
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(i), 1'b0, "refill");
    step(1'b1, 8'h77, 1'b1, "rw_full");
    check("rw_full_oldest", 32'(rd_data), 32'h00);
    check("rw_full_clear", 32'(full), 32'd0);
    while (exp_q.size() != 0) step(1'b0, 8'h00, 1'b1, "drain2");

    // Simultaneous read and write while empty: write wins, read dropped.
    step(1'b1, 8'h3C, 1'b1, "rw_empty");
    check("rw_empty_clear", 32'(empty), 32'd0);
    step(1'b0, 8'h00, 1'b1, "rd_3c");

    // Random traffic with a cycle budget. Most requests are gated by the
    // reference flags, and some are sent ungated to hit the drop rules.
    writes     = 0;
    words_read = 0;
    n          = 0;
    while ((writes < 150 || words_read < 120) && n < 3000) begin
      logic wr;
      logic rd;
      logic gate;
      wr   = ($urandom_range(0, 99) < 55);
      rd   = ($urandom_range(0, 99) < 50);
      gate = ($urandom_range(0, 9) != 0);
      if (gate) begin
        wr = wr && (exp_q.size() != DEPTH);
        rd = rd && (exp_q.size() != 0);
      end
      if (wr && exp_q.size() != DEPTH) writes++;
      step(wr, DW'($urandom_range(0, 255)), rd, "random");
      n++;
    end
    check("random_budget", 32'(n < 3000), 32'd1);

    // Reset mid-stream discards stored words.
    for (int i = 0; i < 5; i++) step(1'b1, DW'(8'h10 + i), 1'b0, "pre_rst");
    do_reset("mid_reset");
    step(1'b1, 8'h5A, 1'b0, "post_rst_wr");
    step(1'b0, 8'h00, 1'b1, "post_rst_rd");
    check("post_rst_5a", 32'(rd_data), 32'h5A);
    step(1'b0, 8'h00, 1'b1, "post_rst_empty");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
